// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus for sync_fifo_param: write, read, status and error pulses.
// Latency and backpressure are set by the FIFO; this interface only carries the signals.
// Backpressure is reported through full/overflow and empty/underflow.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              wr;
  logic [DATA_W-1:0] data_in;
  logic              rd;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr, data_in, rd,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr, data_in, rd,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and error pulses.
// Latency: 1 cycle registered read (FWFT=0), or head word shown the cycle after the write (FWFT=1).
// Backpressure: a write at full is accepted only alongside a read; rejected requests pulse overflow/underflow.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int AFULL_TH  = 28,
  parameter int AEMPTY_TH = 4,
  parameter bit FWFT      = 1'b0
) (
  input logic i_clk,
  input logic i_rst,
  sync_fifo_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AFULL_CNT  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_CNT = AEMPTY_TH[ADDR_W:0];

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [ADDR_W:0]   w_ptr_diff;
  logic [DATA_W-1:0] w_head;

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_rd_acc   = bus.rd && !w_empty;
  // At full, a write is admitted only because the same-cycle read frees its slot.
  assign w_wr_acc   = bus.wr && (!w_full || w_rd_acc);
  assign w_ptr_diff = r_wr_ptr - r_rd_ptr;
  assign w_head     = r_mem[r_rd_ptr[ADDR_W-1:0]];

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr_acc) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= bus.data_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr_acc && !w_rd_acc) begin
        r_count <= r_count + 1'b1;
      end else if (w_rd_acc && !w_wr_acc) begin
        r_count <= r_count - 1'b1;
      end
      r_overflow  <= bus.wr && !w_wr_acc;
      r_underflow <= bus.rd && w_empty;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.data_out = w_empty ? '0 : w_head;
    end else begin : g_std
      logic [DATA_W-1:0] r_dout;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_dout <= '0;
        end else if (w_rd_acc) begin
          r_dout <= w_head;
        end
      end
      assign bus.data_out = r_dout;
    end
  endgenerate

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= AFULL_CNT);
  assign bus.almost_empty = (r_count <= AEMPTY_CNT);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  // The pointer MSBs carry the same occupancy information as the count register.
  a_ptr_count: assert property (@(posedge i_clk) disable iff (i_rst) w_ptr_diff == r_count);
endmodule
